// File: rtl/free_list_ctrl_pkg.sv
// Shared types for the free-list controller: PR index type, FSM states and
// a small index helper used by the round-robin arbiters.
// The PHYS_REG_* macros normally come from the core's global defines; the
// fallbacks below only exist so the block builds stand-alone.
`ifndef PHYS_REG_SZ
`define PHYS_REG_SZ 64
`endif
`ifndef PHYS_REG_IDX_SZ
`define PHYS_REG_IDX_SZ 6
`endif

package free_list_ctrl_pkg;

   localparam int PRW = `PHYS_REG_IDX_SZ + 1;

   typedef logic [PRW-1:0] phys_reg_t;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } fl_ctrl_state_t;

   // Next requester index after idx, wrapping at n.
   function automatic int next_idx(input int idx, input int n);
      return (idx + 1) % n;
   endfunction

endpackage

// File: rtl/free_list_ctrl_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer,
// searching cyclically. The pointer moves past the winner only on cycles
// where en is high; with en low no grant is issued and the pointer holds.
module rr_arbiter
   import free_list_ctrl_pkg::*;
#(
   parameter int N = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] req,
   input  logic         en,
   output logic [N-1:0] gnt
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr_q;
   logic [PW-1:0] ptr_d;
   logic          found;

   // Two passes: indices at/after the pointer first, then the wrapped ones.
   always_comb begin
      gnt   = '0;
      ptr_d = ptr_q;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!found && req[i] && (i >= int'(ptr_q))) begin
            found = 1'b1;
            if (en) begin
               gnt[i] = 1'b1;
               ptr_d  = PW'(next_idx(i, N));
            end
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!found && req[i] && (i < int'(ptr_q))) begin
            found = 1'b1;
            if (en) begin
               gnt[i] = 1'b1;
               ptr_d  = PW'(next_idx(i, N));
            end
         end
      end
   end

   // Pointer register, cleared to requester 0 on reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/free_list_ctrl.sv
// Free-list sequencer/arbiter. After reset it waits one cycle, then pushes
// INIT_FIRST_PR..INIT_LAST_PR into the free list, then arbitrates the single
// dequeue port among allocators and the single enqueue port among releasers.
// Optional feature macro: FREE_LIST_BYPASS_EN (forward a released PR straight
// to an allocator while the free list is empty).
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   INIT  | one idle cycle after reset, then one enqueue of init_cnt per cycle
//   RUN   | ready=1, round-robin alloc/free arbitration
module free_list_ctrl
   import free_list_ctrl_pkg::*;
#(
   parameter int NUM_ALLOC     = 2,
   parameter int NUM_FREE      = 2,
   parameter int INIT_FIRST_PR = 32,
   parameter int INIT_LAST_PR  = `PHYS_REG_SZ - 1
) (
   input  logic                 clk,
   input  logic                 reset,
   output logic                 ready,
   input  logic [NUM_ALLOC-1:0] alloc_req,
   output logic [NUM_ALLOC-1:0] alloc_gnt,
   output phys_reg_t            alloc_pr,
   input  logic [NUM_FREE-1:0]  free_req,
   input  phys_reg_t            free_pr [NUM_FREE],
   output logic [NUM_FREE-1:0]  free_ack,
   input  phys_reg_t            fl_tail_pr,
   input  logic                 fl_is_empty,
   input  logic                 fl_is_full,
   output logic                 fl_dequeue_en,
   output logic                 fl_enqueue_en,
   output phys_reg_t            fl_enqueue_pr
);

   fl_ctrl_state_t state_q, state_d;
   phys_reg_t      init_cnt_q, init_cnt_d;
   logic           started_q, started_d;

   logic           run;
   logic           deq_from_list;
   logic           free_acc;
   logic           bypass;
   logic           alloc_en;
   logic [NUM_FREE-1:0] free_gnt;
   phys_reg_t      rel_pr;

   // Reset gates every output in the same cycle, not just from the next one.
   assign run           = (state_q == RUN) && !reset;
   assign deq_from_list = run && (|alloc_req) && !fl_is_empty;
   // A full list still takes an enqueue when it is dequeued in the same cycle.
   // deq_from_list never looks at the release side, so there is no loop.
   assign free_acc      = run && (|free_req) && (!fl_is_full || deq_from_list);

`ifdef FREE_LIST_BYPASS_EN
   assign bypass = run && (|alloc_req) && fl_is_empty && free_acc;
`else
   assign bypass = 1'b0;
`endif

   assign alloc_en = deq_from_list || bypass;

   rr_arbiter #(.N(NUM_ALLOC)) u_alloc_arb (
      .clk   (clk),
      .reset (reset),
      .req   (alloc_req),
      .en    (alloc_en),
      .gnt   (alloc_gnt)
   );

   rr_arbiter #(.N(NUM_FREE)) u_free_arb (
      .clk   (clk),
      .reset (reset),
      .req   (free_req),
      .en    (free_acc),
      .gnt   (free_gnt)
   );

   assign free_ack = free_gnt;

   // Select the PR of the accepted releaser (one-hot OR mux).
   always_comb begin
      rel_pr = '0;
      for (int j = 0; j < NUM_FREE; j++) begin
         if (free_gnt[j]) begin
            rel_pr = rel_pr | free_pr[j];
         end
      end
   end

   // Next state, init counter and free-list strobes.
   always_comb begin
      state_d       = state_q;
      init_cnt_d    = init_cnt_q;
      started_d     = 1'b1;
      ready         = 1'b0;
      fl_enqueue_en = 1'b0;
      fl_enqueue_pr = '0;
      fl_dequeue_en = 1'b0;
      alloc_pr      = '0;
      if (state_q == INIT) begin
         if (started_q && !reset) begin
            fl_enqueue_en = 1'b1;
            fl_enqueue_pr = init_cnt_q;
            init_cnt_d    = init_cnt_q + 1'b1;
            if (init_cnt_q == PRW'(INIT_LAST_PR)) begin
               state_d = RUN;
            end
         end
      end else if (!reset) begin
         ready         = 1'b1;
         fl_dequeue_en = alloc_en;
         if (bypass) begin
            alloc_pr = rel_pr;
         end else if (deq_from_list) begin
            alloc_pr = fl_tail_pr;
         end
         fl_enqueue_en = free_acc;
         if (free_acc) begin
            fl_enqueue_pr = rel_pr;
         end
      end
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= INIT;
         init_cnt_q <= PRW'(INIT_FIRST_PR);
         started_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         started_q  <= started_d;
      end
   end

endmodule

// File: tb/tb_free_list_ctrl.sv
// Scoreboard bench for free_list_ctrl: a driver applies stimulus and pushes
// the reference model's expected outputs; a monitor pops and compares them.
`ifndef PHYS_REG_SZ
`define PHYS_REG_SZ 64
`endif
`ifndef PHYS_REG_IDX_SZ
`define PHYS_REG_IDX_SZ 6
`endif

module tb_free_list_ctrl;
   import free_list_ctrl_pkg::*;

   localparam int NA    = 2;
   localparam int NF    = 2;
   localparam int FIRST = 32;
   localparam int LAST  = 35;
   localparam int CAP   = 6;

   logic            clk = 1'b0;
   logic            reset;
   logic            ready;
   logic [NA-1:0]   alloc_req;
   logic [NA-1:0]   alloc_gnt;
   phys_reg_t       alloc_pr;
   logic [NF-1:0]   free_req;
   phys_reg_t       free_pr [NF];
   logic [NF-1:0]   free_ack;
   phys_reg_t       fl_tail_pr;
   logic            fl_is_empty;
   logic            fl_is_full;
   logic            fl_dequeue_en;
   logic            fl_enqueue_en;
   phys_reg_t       fl_enqueue_pr;

   always #5 clk = ~clk;

   free_list_ctrl #(
      .NUM_ALLOC     (NA),
      .NUM_FREE      (NF),
      .INIT_FIRST_PR (FIRST),
      .INIT_LAST_PR  (LAST)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .ready         (ready),
      .alloc_req     (alloc_req),
      .alloc_gnt     (alloc_gnt),
      .alloc_pr      (alloc_pr),
      .free_req      (free_req),
      .free_pr       (free_pr),
      .free_ack      (free_ack),
      .fl_tail_pr    (fl_tail_pr),
      .fl_is_empty   (fl_is_empty),
      .fl_is_full    (fl_is_full),
      .fl_dequeue_en (fl_dequeue_en),
      .fl_enqueue_en (fl_enqueue_en),
      .fl_enqueue_pr (fl_enqueue_pr)
   );

   typedef struct {
      logic          rdy;
      logic [NA-1:0] gnt;
      phys_reg_t     apr;
      logic [NF-1:0] ack;
      logic          deq;
      logic          enq;
      phys_reg_t     epr;
   } exp_t;

   exp_t      exp_q [$];
   phys_reg_t fl_q  [$];
   int        checks = 0;
   int        errors = 0;

   // Reference model state: 0 = idle after reset, 1 = filling, 2 = running.
   int phase = 0;
   int cnt   = FIRST;
   int aptr  = 0;
   int fptr  = 0;

   task automatic model(output exp_t e);
      int aw;
      int fw;
      bit deq;
      bit acc;
      e.rdy = 1'b0; e.gnt = '0; e.apr = '0; e.ack = '0;
      e.deq = 1'b0; e.enq = 1'b0; e.epr = '0;
      aw = -1;
      fw = -1;
      if (reset) begin
         phase = 0; cnt = FIRST; aptr = 0; fptr = 0;
      end else if (phase == 0) begin
         phase = 1;
      end else if (phase == 1) begin
         e.enq = 1'b1;
         e.epr = phys_reg_t'(cnt);
         if (cnt == LAST) phase = 2;
         cnt++;
      end else begin
         e.rdy = 1'b1;
         for (int k = 0; k < NA; k++)
            if (aw < 0 && alloc_req[(aptr + k) % NA]) aw = (aptr + k) % NA;
         for (int k = 0; k < NF; k++)
            if (fw < 0 && free_req[(fptr + k) % NF]) fw = (fptr + k) % NF;
         deq = (aw >= 0) && !fl_is_empty;
         acc = (fw >= 0) && (!fl_is_full || deq);
         if (deq) e.apr = fl_tail_pr;
`ifdef FREE_LIST_BYPASS_EN
         if (aw >= 0 && fl_is_empty && acc) begin
            deq   = 1'b1;
            e.apr = free_pr[fw];
         end
`endif
         if (deq) begin
            e.gnt[aw] = 1'b1;
            e.deq     = 1'b1;
            aptr      = (aw + 1) % NA;
         end
         if (acc) begin
            e.ack[fw] = 1'b1;
            e.enq     = 1'b1;
            e.epr     = free_pr[fw];
            fptr      = (fw + 1) % NF;
         end
      end
   endtask

   // One cycle of stimulus; env=1 derives empty/full/tail from the bench's
   // own free-list queue, otherwise the given values are forced.
   task automatic step(input bit r, input logic [NA-1:0] ar,
                       input logic [NF-1:0] fr, input phys_reg_t p0,
                       input phys_reg_t p1, input bit env, input bit emp,
                       input bit ful, input phys_reg_t tail);
      exp_t e;
      bit   byp;
      reset       = r;
      alloc_req   = ar;
      free_req    = fr;
      free_pr[0]  = p0;
      free_pr[1]  = p1;
      if (env) begin
         fl_is_empty = (fl_q.size() == 0);
         fl_is_full  = (fl_q.size() >= CAP);
         fl_tail_pr  = fl_is_empty ? '0 : fl_q[0];
      end else begin
         fl_is_empty = emp;
         fl_is_full  = ful;
         fl_tail_pr  = tail;
      end
      model(e);
      exp_q.push_back(e);
      byp = e.deq && fl_is_empty;
      @(posedge clk);
      if (r) begin
         fl_q.delete();
      end else if (!byp) begin
         if (e.deq && fl_q.size() > 0) void'(fl_q.pop_front());
         if (e.enq && fl_q.size() < CAP) fl_q.push_back(e.epr);
      end
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compare DUT outputs against the oldest expectation mid-cycle.
   initial begin : monitor
      exp_t m;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            m = exp_q.pop_front();
            chk("ready",         32'(ready),         32'(m.rdy));
            chk("alloc_gnt",     32'(alloc_gnt),     32'(m.gnt));
            chk("alloc_pr",      32'(alloc_pr),      32'(m.apr));
            chk("free_ack",      32'(free_ack),      32'(m.ack));
            chk("fl_dequeue_en", 32'(fl_dequeue_en), 32'(m.deq));
            chk("fl_enqueue_en", 32'(fl_enqueue_en), 32'(m.enq));
            chk("fl_enqueue_pr", 32'(fl_enqueue_pr), 32'(m.epr));
         end
      end
   end

   initial begin : driver
      bit r;
      reset = 1'b1; alloc_req = '0; free_req = '0;
      free_pr[0] = '0; free_pr[1] = '0;
      fl_is_empty = 1'b1; fl_is_full = 1'b0; fl_tail_pr = '0;
      @(posedge clk); #1;

      // Reset, idle cycle, four init enqueues, first ready cycle.
      repeat (2) step(1, '0, '0, '0, '0, 1, 0, 0, '0);
      repeat (6) step(0, '0, '0, '0, '0, 1, 0, 0, '0);

      // Both allocators held: grants alternate, PR follows the list head.
      repeat (4) step(0, 2'b11, '0, '0, '0, 1, 0, 0, '0);

      // Empty list with a concurrent release.
      step(0, 2'b01, 2'b01, 7'd7, '0, 0, 1, 0, '0);

      // Full list: release refused alone, accepted alongside a dequeue.
      step(0, 2'b00, 2'b01, 7'd9, '0, 0, 0, 1, 7'd5);
      step(0, 2'b01, 2'b01, 7'd9, '0, 0, 0, 1, 7'd5);

      // Random traffic with occasional resets.
      repeat (400) begin
         r = ($urandom_range(0, 99) == 0);
         step(r, NA'($urandom), NF'($urandom),
              phys_reg_t'($urandom_range(0, 63)),
              phys_reg_t'($urandom_range(0, 63)), 1, 0, 0, '0);
      end

      // Make sure we are in RUN, then reset with requests pending.
      for (int i = 0; i < 10 && phase != 2; i++)
         step(0, '0, '0, '0, '0, 1, 0, 0, '0);
      step(1, 2'b11, 2'b11, 7'd3, 7'd4, 1, 0, 0, '0);
      repeat (6) step(0, '0, '0, '0, '0, 1, 0, 0, '0);
      repeat (2) step(0, 2'b11, 2'b11, 7'd11, 7'd12, 1, 0, 0, '0);

      repeat (3) @(posedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
